// File: rtl/rv32_uart_tx_mmio_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_uart_tx_mmio_if : RAM-style word bus shared with the data RAM    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface rv32_uart_tx_mmio_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  bus_wr_en;
  logic [3:0]            bus_wr_strobe;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wr_data;
  logic [31:0]           bus_rd_data;
  logic                  bus_rd_valid;

  modport master (
    output bus_wr_en, bus_wr_strobe, bus_addr, bus_wr_data,
    input  bus_rd_data, bus_rd_valid
  );

  modport slave (
    input  bus_wr_en, bus_wr_strobe, bus_addr, bus_wr_data,
    output bus_rd_data, bus_rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/rv32_uart_tx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_uart_tx_mmio : memory-mapped 8N1 UART transmitter with TX FIFO  |
// | Optional irq output and STATUS.irq_en when UART_TX_IRQ_EN is defined |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv32_uart_tx_mmio #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_WADDR  = 16'h4000,
  parameter int                    FIFO_DEPTH  = 8,
  parameter logic [15:0]           DEFAULT_DIV = 16'd868
) (
  input  logic                    clk,
  input  logic                    reset_n,
  rv32_uart_tx_mmio_if.slave      bus,
`ifdef UART_TX_IRQ_EN
  output logic                    irq,
`endif
  output logic                    uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  tx_state_e        state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      div_q, div_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             hit;
  logic [1:0]       reg_sel;
  logic             push_req, push_ok, pop;
  logic             status_wr, div_wr0, div_wr1;
  logic             fifo_empty, fifo_full, busy;
  logic [15:0]      div_load;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign hit       = (bus.bus_addr[ADDR_WIDTH-1:2] == BASE_WADDR[ADDR_WIDTH-1:2]);
  assign reg_sel   = bus.bus_addr[1:0];
  assign push_req  = bus.bus_wr_en & hit & bus.bus_wr_strobe[0] & (reg_sel == 2'd0);
  assign status_wr = bus.bus_wr_en & hit & bus.bus_wr_strobe[0] & (reg_sel == 2'd1);
  assign div_wr0   = bus.bus_wr_en & hit & bus.bus_wr_strobe[0] & (reg_sel == 2'd2);
  assign div_wr1   = bus.bus_wr_en & hit & bus.bus_wr_strobe[1] & (reg_sel == 2'd2);

  // Flags come from registered state only, so a same-cycle pop never frees a slot for a push.
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_ok    = push_req & ~fifo_full;
  assign busy       = (state_q != S_IDLE);
  assign div_load   = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

  assign unused_bits = ^{bus.bus_wr_data[31:16], bus.bus_wr_strobe[3:2]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.bus_wr_data[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d    = ovf_q;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    if (status_wr && bus.bus_wr_data[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (div_wr0) begin
      div_d[7:0] = bus.bus_wr_data[7:0];
    end
    if (div_wr1) begin
      div_d[15:8] = bus.bus_wr_data[15:8];
    end
`ifdef UART_TX_IRQ_EN
    if (status_wr) begin
      irq_en_d = bus.bus_wr_data[4];
    end
`endif
    irq_d = irq_en_q & fifo_empty & ~busy;
  end

  always_comb begin
    status_word       = '0;
    status_word[14:8] = 7'(cnt_q);
    status_word[4]    = irq_en_q;
    status_word[3]    = ovf_q;
    status_word[2]    = fifo_empty;
    status_word[1]    = fifo_full;
    status_word[0]    = busy;
  end

  // Read data reflects pre-write register values of this cycle.
  always_comb begin
    rd_valid_d = hit;
    rd_data_d  = '0;
    if (hit) begin
      case (reg_sel)
        2'd1:    rd_data_d = status_word;
        2'd2:    rd_data_d = {16'h0000, div_q};
        default: rd_data_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = div_load;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = div_load;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = div_load;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = div_load;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state to keep uart_tx glitch-free.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      div_q      <= DEFAULT_DIV;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.bus_rd_data  = rd_data_q;
  assign bus.bus_rd_valid = rd_valid_q;
  assign uart_tx          = tx_q;

`ifdef UART_TX_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule
`default_nettype wire
